// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a PWM input, rise to rise.
// Results are published on each rising edge that closes a full period and held
// until the next publish; meas_valid/meas_ack form a simple handshake with a sticky
// overrun flag. A period counter that saturates flags a stuck-high or stuck-low input.
// Optional build macro PWM_CAPTURE_SYNC_EN: adds a two-flop synchronizer on pwm_in
// for asynchronous sources (adds one clock of latency, measured values unchanged).
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pwm_in,
    input  logic             meas_ack,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             overrun,
    output logic             stuck_high,
    output logic             stuck_low
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg;
    logic [CNT_W-1:0] period_cnt_reg;
    logic [CNT_W-1:0] high_cnt_reg;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] high_time_reg;
    logic             meas_valid_reg;
    logic             overrun_reg;
    logic             stuck_high_reg;
    logic             stuck_low_reg;
    logic             s_reg;
    logic             s_d_reg;

`ifdef PWM_CAPTURE_SYNC_EN
    logic sync1_reg;

    // Two-flop synchronizer; the second stage is the sampled signal s
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            s_reg     <= 1'b0;
        end else begin
            sync1_reg <= pwm_in;
            s_reg     <= sync1_reg;
        end
    end
`else
    // Single input register; the source is assumed synchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg <= 1'b0;
        end else begin
            s_reg <= pwm_in;
        end
    end
`endif

    // Delayed copy of s for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d_reg <= 1'b0;
        end else begin
            s_d_reg <= s_reg;
        end
    end

    logic             rise;
    logic             fall;
    logic             publish;
    logic [CNT_W-1:0] period_inc;
    logic             period_limit;

    assign rise         = s_reg & ~s_d_reg;
    assign fall         = ~s_reg & s_d_reg;
    // Saturating increment: the counter never wraps
    assign period_inc   = (period_cnt_reg == CNT_MAX) ? CNT_MAX : period_cnt_reg + CNT_ONE;
    assign period_limit = (period_inc == CNT_MAX);
    assign publish      = enable && (state_reg == MEAS_LOW) && rise;

    // Measurement FSM with period/high counters and stuck detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            period_cnt_reg <= '0;
            high_cnt_reg   <= '0;
            stuck_high_reg <= 1'b0;
            stuck_low_reg  <= 1'b0;
        end else if (!enable) begin
            state_reg      <= IDLE;
            period_cnt_reg <= '0;
            high_cnt_reg   <= '0;
            stuck_high_reg <= 1'b0;
            stuck_low_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg      <= WAIT_RISE;
                    period_cnt_reg <= '0;
                    high_cnt_reg   <= '0;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state_reg      <= MEAS_HIGH;
                        period_cnt_reg <= CNT_ONE;
                        high_cnt_reg   <= CNT_ONE;
                        stuck_high_reg <= 1'b0;
                        stuck_low_reg  <= 1'b0;
                    end else begin
                        // Keep counting so a dead-low input is still flagged;
                        // a stuck-high episode is not re-reported as stuck-low
                        period_cnt_reg <= period_inc;
                        if (period_limit && !stuck_high_reg) begin
                            stuck_low_reg <= 1'b1;
                        end
                    end
                end
                MEAS_HIGH: begin
                    period_cnt_reg <= period_inc;
                    if (period_limit) begin
                        stuck_high_reg <= 1'b1;
                        state_reg      <= WAIT_RISE;
                    end else if (fall) begin
                        state_reg <= MEAS_LOW;
                    end else begin
                        high_cnt_reg <= high_cnt_reg + CNT_ONE;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        state_reg      <= MEAS_HIGH;
                        period_cnt_reg <= CNT_ONE;
                        high_cnt_reg   <= CNT_ONE;
                        stuck_high_reg <= 1'b0;
                        stuck_low_reg  <= 1'b0;
                    end else begin
                        period_cnt_reg <= period_inc;
                        if (period_limit) begin
                            stuck_low_reg <= 1'b1;
                            state_reg     <= WAIT_RISE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Result registers, valid/ack handshake and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_reg     <= '0;
            high_time_reg  <= '0;
            meas_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            if (publish) begin
                period_reg     <= period_cnt_reg;
                high_time_reg  <= high_cnt_reg;
                meas_valid_reg <= 1'b1;
                // An ack landing on the publish edge consumes the old result
                if (meas_valid_reg && !meas_ack) begin
                    overrun_reg <= 1'b1;
                end
            end else if (meas_ack) begin
                meas_valid_reg <= 1'b0;
            end
            if (!enable) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign period     = period_reg;
    assign high_time  = high_time_reg;
    assign meas_valid = meas_valid_reg;
    assign overrun    = overrun_reg;
    assign stuck_high = stuck_high_reg;
    assign stuck_low  = stuck_low_reg;

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 16, width of the period and high-time counters and results; legal range 4..24.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  1 = measure; 0 = return to IDLE and discard any partial measurement.
REQ-005 pwm_in  input  1  PWM waveform produced by the upstream PWM generator.
REQ-006 period  output  CNT_W  clocks between two consecutive rising edges of the last completed measurement.
REQ-007 high_time  output  CNT_W  clocks pwm_in was high within that period.
REQ-008 meas_valid  output  1  period/high_time hold a new unacknowledged result.
REQ-009 meas_ack  input  1  consumer acknowledge; clears meas_valid.
REQ-010 overrun  output  1  sticky; a result was overwritten while meas_valid was 1.
REQ-011 stuck_high, stuck_low  output  1 each  pwm_in held constant for 2^CNT_W-1 clocks.

Function
REQ-012 Sampled signal s = pwm_in after the input stage (REQ-030/031); s_d = s delayed one clock; rise = s & ~s_d; fall = ~s & s_d.
REQ-013 FSM states: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
REQ-014 IDLE: enable=1 -> WAIT_RISE next cycle; counters held at 0.
REQ-015 WAIT_RISE: rise -> MEAS_HIGH; period_cnt=1, high_cnt=1.
REQ-016 MEAS_HIGH: each cycle period_cnt+1, high_cnt+1; fall -> MEAS_LOW.
REQ-017 MEAS_LOW: each cycle period_cnt+1, high_cnt held; rise -> publish, then MEAS_HIGH with period_cnt=1, high_cnt=1.
REQ-018 A fall coincident with a rise cannot occur; 1-cycle pulses give high_time=1.
REQ-019 Publish: period<=period_cnt, high_time<=high_cnt, meas_valid<=1 on the clock edge at which rise is detected; outputs otherwise hold.
REQ-020 meas_ack while meas_valid=1 clears meas_valid next edge; meas_ack with meas_valid=0 is ignored.
REQ-021 Publish and meas_ack in the same cycle: meas_valid stays 1 with new values; overrun not set.
REQ-022 Publish while meas_valid=1 and meas_ack=0: values overwritten, overrun<=1; overrun cleared only by reset or enable=0.
REQ-023 Timeout: period_cnt reaching 2^CNT_W-1 in MEAS_HIGH sets stuck_high; in MEAS_LOW or WAIT_RISE (WAIT_RISE counts with period_cnt) sets stuck_low; FSM -> WAIT_RISE, no publish, period_cnt saturates.
REQ-024 stuck_high/stuck_low cleared on the next rise; never both 1.
REQ-025 enable=0 in any state: next state IDLE, counters 0, stuck flags and overrun cleared; period, high_time, meas_valid retained.
REQ-026 Counters never wrap; saturation at 2^CNT_W-1 is the only overflow behaviour.

Reset
REQ-027 rst_n=0 asynchronously forces: state IDLE, counters 0, s/s_d/sync flops 0, period=0, high_time=0, meas_valid=0, overrun=0, stuck_high=0, stuck_low=0.
REQ-028 Reset mid-measurement discards partial counts; first result after release requires a full rise-to-rise interval.
REQ-029 Deassertion of rst_n takes effect at the next rising clk edge.

Configuration
REQ-030 Macro PWM_CAPTURE_SYNC_EN defined: pwm_in passes through a two-flop synchronizer; rise detected 3 clocks after pwm_in first sampled high.
REQ-031 Macro undefined: s = pwm_in registered once (synchronous source assumed); rise detected 2 clocks after pwm_in first sampled high; measured values identical in both builds.

Verification
REQ-032 Periodic pwm_in, 16-clock period, 4 high, enable=1, ack each result -> period=16, high_time=4, meas_valid pulses once per period, overrun=0.
REQ-033 Change to 16-clock period, 12 high after two periods -> first complete period after change reports high_time=12, period=16.
REQ-034 CNT_W=8, pwm_in held 0 after one rise -> stuck_low=1 at period_cnt=255, no meas_valid; next rise clears stuck_low.
REQ-035 meas_ack tied 0, 3 periods -> overrun=1 after second publish, outputs show third result; ack and publish same cycle -> overrun unchanged.
REQ-036 rst_n pulsed low mid MEAS_HIGH -> all outputs 0 immediately (asynchronous); first valid after two rises.
REQ-037 enable dropped in MEAS_LOW -> IDLE, no publish, prior period/high_time retained, overrun cleared.
